// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, reads the async instruction memory, and queues {pc, inst} to decode.
// Optional static backward-taken branch prediction when FETCH_QUEUE_BTFN_EN is defined.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_pc,
  input  logic [31:0]              imem_inst,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     dec_ready,
  output logic                     dec_valid,
  output logic [31:0]              dec_pc,
  output logic [31:0]              dec_inst,
  output logic                     dec_pred_taken,
  output logic [$clog2(DEPTH):0]   fq_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

  logic [31:0]      pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];

  logic        pop;
  logic        push;
  logic [31:0] next_pc;

  always_comb begin
    pop  = (count != '0) & dec_ready & ~redirect_valid;
    push = ~redirect_valid & ((count != FULL) | pop);
  end

`ifdef FETCH_QUEUE_BTFN_EN
  logic        pred;
  logic        pred_mem [DEPTH];
  logic [31:0] b_imm;

  // B-type with sign bit set means a backward branch: predict taken.
  always_comb begin
    b_imm   = {{19{imem_inst[31]}}, imem_inst[31], imem_inst[7],
               imem_inst[30:25], imem_inst[11:8], 1'b0};
    pred    = (imem_inst[6:0] == 7'b1100011) & imem_inst[31];
    next_pc = pred ? (pc + b_imm) : (pc + 32'd4);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) pred_mem[i] <= 1'b0;
    end else if (push) begin
      pred_mem[wr_ptr] <= pred;
    end
  end

  assign dec_pred_taken = pred_mem[rd_ptr];
`else
  always_comb begin
    next_pc = pc + 32'd4;
  end

  assign dec_pred_taken = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc     <= redirect_pc & ~32'h3;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= pc;
        inst_mem[wr_ptr] <= imem_inst;
        wr_ptr           <= wr_ptr + 1'b1;
        pc               <= next_pc;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Head storage drives decode directly; no path from dec_ready to dec_*.
  assign imem_pc   = pc;
  assign dec_valid = (count != '0);
  assign dec_pc    = pc_mem[rd_ptr];
  assign dec_inst  = inst_mem[rd_ptr];
  assign fq_count  = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_ready = 1'b0;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
  logic        dec_pred_taken;
  logic [2:0]  fq_count;

  logic [31:0] imem [64];
  assign imem_inst = imem[imem_pc[7:2]];

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_pc(imem_pc), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_ready(dec_ready), .dec_valid(dec_valid), .dec_pc(dec_pc),
    .dec_inst(dec_inst), .dec_pred_taken(dec_pred_taken), .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } entry_t;

  entry_t      exp_q[$];
  logic [31:0] mpc = '0;
  int          total = 0;
  int          bad = 0;

`ifdef FETCH_QUEUE_BTFN_EN
  localparam bit BTFN = 1'b1;
`else
  localparam bit BTFN = 1'b0;
`endif

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void predict(input logic [31:0] pc, input logic [31:0] inst,
                                  output logic [31:0] npc, output logic p);
    npc = pc + 32'd4;
    p   = 1'b0;
    if (BTFN && inst[6:0] == 7'b1100011) begin
      logic [12:0] raw;
      int          imm;
      raw = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      imm = int'($signed(raw));
      if (imm < 0) begin
        npc = pc + 32'(imm);
        p   = 1'b1;
      end
    end
  endfunction

  // Reference model: apply the effect of the clock edge that just passed.
  task automatic model_edge();
    logic [31:0] npc;
    logic        p;
    entry_t      e;
    if (redirect_valid) begin
      exp_q.delete();
      mpc = redirect_pc & ~32'h3;
    end else if (exp_q.size() < DEPTH) begin
      predict(mpc, imem[mpc[7:2]], npc, p);
      e.pc = mpc; e.inst = imem[mpc[7:2]]; e.pred = p;
      exp_q.push_back(e);
      mpc = npc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  // Called at posedge+1; asserts reset mid-cycle and checks the async clear.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    redirect_valid = 1'b0;
    #1;
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_inst", dec_inst, 32'h0);
    chk("rst_pred", 32'(dec_pred_taken), 32'd0);
    chk("rst_count", 32'(fq_count), 32'd0);
    chk("rst_imem_pc", imem_pc, 32'h0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    exp_q.delete();
    mpc = 32'h0;
  endtask

  // Monitor: compares DUT state with the model and pops on every handshake.
  always @(negedge clk) begin
    entry_t e;
    if (!reset) begin
      chk("fq_count", 32'(fq_count), 32'(exp_q.size()));
      chk("imem_pc", imem_pc, mpc);
      chk("dec_valid", 32'(dec_valid), 32'(exp_q.size() != 0));
      if (dec_valid && dec_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_empty: got pop with dec_pc %h expected no entry", dec_pc);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc", dec_pc, e.pc);
          chk("pop_inst", dec_inst, e.inst);
          chk("pop_pred", 32'(dec_pred_taken), 32'(e.pred));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = $urandom;
    imem[0]  = 32'h1F400293;
    imem[1]  = 32'h00440413;
    for (int i = 2; i < 10; i++) imem[i] = {$urandom_range(0, 32'hFFFFFF), 7'h0, 1'b0} | 32'h13;
    imem[10] = 32'hFC029CE3;
    imem[11] = 32'h00A38233;
    for (int i = 61; i < 64; i++) imem[i] = 32'h00000013;

    do_reset();

    // first fetches and latency
    dec_ready = 1'b1;
    step();
    chk("t1_pc0", dec_pc, 32'h0);
    chk("t1_inst0", dec_inst, 32'h1F400293);
    step();
    chk("t1_pc1", dec_pc, 32'h4);
    chk("t1_inst1", dec_inst, 32'h00440413);

    // fill, stall, then drain at full rate
    do_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("t2_count", 32'(fq_count), 32'd4);
    chk("t2_pc_hold", imem_pc, 32'h10);
    dec_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t3_count_full", 32'(fq_count), 32'd4);
      chk("t3_pc_step", imem_pc, 32'h10 + 32'(4 * k));
    end

    // redirect with three entries queued
    do_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h2E;
    step();
    chk("t4_count", 32'(fq_count), 32'd0);
    chk("t4_valid", 32'(dec_valid), 32'd0);
    chk("t4_pc", imem_pc, 32'h2C);
    redirect_valid = 1'b0;
    step();
    chk("t4_dec_pc", dec_pc, 32'h2C);
    chk("t4_dec_inst", dec_inst, 32'h00A38233);

    // redirect concurrent with ready: no pop credited
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h1C;
    dec_ready = 1'b1;
    step();
    chk("t5_count", 32'(fq_count), 32'd0);
    redirect_valid = 1'b0;
    dec_ready = 1'b0;
    step();
    step();
    chk("t6_pre_count", 32'(fq_count), 32'd2);
    chk("t6_pre_pc", imem_pc, 32'h24);
    do_reset();

    // backward branch prediction
    redirect_valid = 1'b1;
    redirect_pc = 32'h28;
    step();
    redirect_valid = 1'b0;
    dec_ready = 1'b1;
    step();
    chk("t7_dec_pc", dec_pc, 32'h28);
    chk("t7_next_pc", imem_pc, BTFN ? 32'h0 : 32'h2C);
    chk("t7_pred", 32'(dec_pred_taken), BTFN ? 32'd1 : 32'd0);

    // PC wrap at top of address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFFFFF7;
    step();
    chk("wrap_start", imem_pc, 32'hFFFFFFF4);
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("wrap_zero", imem_pc, 32'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      dec_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      step();
    end
    redirect_valid = 1'b0;
    dec_ready = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
